// File: rtl/demux_stream.sv
// demux_stream
//   Registered 1-to-CHANNELS stream demultiplexer with valid/ready on the
//   input and on every output channel. Each channel owns a one-entry holding
//   register, so a stalled consumer only back-pressures beats addressed to it.
//   Beats whose select is >= CHANNELS are dropped, flagged and counted.
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      active-low asynchronous reset
//   value_i    input beat data
//   sel_i      destination channel for the beat on value_i
//   valid_i    input beat valid
//   ready_o    beat accepted this cycle (combinational from sel_i/ready_i)
//   data_o     channel k data at [k*WIDTH +: WIDTH]
//   valid_o    channel k holds a beat
//   ready_i    consumer k accepts a beat
//   err_o      one-cycle pulse after an out-of-range beat was dropped
//   err_cnt_o  saturating count of dropped beats
//
// Per-channel holding state (full_q[k]):
//   state | meaning
//   EMPTY | full_q[k] = 0, no beat held; slice k is 0 (IDLE_ZERO=1) or stale
//   FULL  | full_q[k] = 1, slice k holds a beat waiting for ready_i[k]
module demux_stream #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 8,
  parameter int SEL_W     = 4,
  parameter int IDLE_ZERO = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [WIDTH-1:0]          value_i,
  input  logic [SEL_W-1:0]          sel_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [CHANNELS*WIDTH-1:0] data_o,
  output logic [CHANNELS-1:0]       valid_o,
  input  logic [CHANNELS-1:0]       ready_i,
  output logic                      err_o,
  output logic [7:0]                err_cnt_o
);

  // One extra bit so the compare also works when 2**SEL_W == CHANNELS.
  localparam logic [SEL_W:0] CH_CODE = (SEL_W+1)'(CHANNELS);

  logic [CHANNELS-1:0]       full_q, full_d;
  logic [CHANNELS*WIDTH-1:0] data_q, data_d;
  logic                      err_q, err_d;
  logic [7:0]                err_cnt_q, err_cnt_d;

  logic in_range;
  logic sel_full;
  logic sel_rdy;
  logic accept;

  assign in_range = ({1'b0, sel_i} < CH_CODE);

  // Look up the addressed channel by compare rather than by indexing with
  // sel_i, so out-of-range codes never index past the channel vectors.
  always_comb begin
    sel_full = 1'b0;
    sel_rdy  = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_i == SEL_W'(k)) begin
        sel_full = full_q[k];
        sel_rdy  = ready_i[k];
      end
    end
  end

  // Out-of-range beats are always accepted (and dropped).
  assign ready_o = rst_i && (!in_range || !sel_full || sel_rdy);
  assign accept  = valid_i && ready_o;

  always_comb begin
    full_d    = full_q;
    data_d    = data_q;
    err_d     = accept && !in_range;
    err_cnt_d = err_cnt_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (accept && in_range && (sel_i == SEL_W'(k))) begin
        // A load wins over a simultaneous drain: the new beat replaces the
        // one leaving, so the channel stays full with no bubble.
        full_d[k]                  = 1'b1;
        data_d[k*WIDTH +: WIDTH]   = value_i;
      end else if (full_q[k] && ready_i[k]) begin
        full_d[k] = 1'b0;
        if (IDLE_ZERO != 0) begin
          data_d[k*WIDTH +: WIDTH] = '0;
        end
      end
    end
    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      full_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      full_q    <= full_d;
      data_q    <= data_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = full_q;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_demux_stream.sv
module tb_demux_stream;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  value_i;
  logic [3:0]  sel_i;
  logic        valid_i;
  logic [7:0]  ready_i;

  logic        ready_o,   ready_o_h;
  logic [63:0] data_o,    data_o_h;
  logic [7:0]  valid_o,   valid_o_h;
  logic        err_o,     err_o_h;
  logic [7:0]  err_cnt_o, err_cnt_o_h;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  demux_stream #(.WIDTH(8), .CHANNELS(8), .SEL_W(4), .IDLE_ZERO(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .value_i(value_i), .sel_i(sel_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  // Hold-last-value build driven by the same stimulus.
  demux_stream #(.WIDTH(8), .CHANNELS(8), .SEL_W(4), .IDLE_ZERO(0)) dut_h (
    .clk_i(clk_i), .rst_i(rst_i), .value_i(value_i), .sel_i(sel_i),
    .valid_i(valid_i), .ready_o(ready_o_h), .data_o(data_o_h), .valid_o(valid_o_h),
    .ready_i(ready_i), .err_o(err_o_h), .err_cnt_o(err_cnt_o_h)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] at(input int ch, input logic [7:0] v);
    logic [63:0] r;
    r = 64'(v) << (8 * ch);
    return r;
  endfunction

  function automatic logic [7:0] onehot(input int ch);
    logic [7:0] r;
    r = 8'h01 << ch;
    return r;
  endfunction

  initial begin
    rst_i   = 1'b0;
    value_i = 8'h00;
    sel_i   = 4'd0;
    valid_i = 1'b1;
    ready_i = 8'h00;
    #2;
    chk("rst_ready",   64'(ready_o),   64'(0));
    chk("rst_valid",   64'(valid_o),   64'(0));
    chk("rst_data",    data_o,         64'(0));
    chk("rst_err",     64'(err_o),     64'(0));
    chk("rst_err_cnt", 64'(err_cnt_o), 64'(0));
    tick();
    chk("rst_hold_valid", 64'(valid_o), 64'(0));
    valid_i = 1'b0;
    rst_i   = 1'b1;

    // Sweep: one beat per cycle, rotating channels, all consumers ready.
    ready_i = 8'hFF;
    for (int i = 0; i < 32; i++) begin
      value_i = 8'(i);
      sel_i   = 4'(i % 8);
      valid_i = 1'b1;
      #1;
      chk("sweep_ready", 64'(ready_o), 64'(1));
      tick();
      chk("sweep_valid", 64'(valid_o), 64'(onehot(i % 8)));
      chk("sweep_data",  data_o,       at(i % 8, 8'(i)));
    end
    valid_i = 1'b0;
    tick();
    chk("sweep_end_valid", 64'(valid_o), 64'(0));
    chk("sweep_end_data",  data_o,       64'(0));

    // Back-pressure on channel 3 while channel 2 keeps flowing.
    ready_i = 8'hF7;
    value_i = 8'hA5; sel_i = 4'd3; valid_i = 1'b1;
    #1;
    chk("bp_first_ready", 64'(ready_o), 64'(1));
    tick();
    value_i = 8'h5A; sel_i = 4'd3;
    #1;
    chk("bp_stall_ready", 64'(ready_o), 64'(0));
    tick();
    chk("bp_held_valid", 64'(valid_o), 64'(8'h08));
    chk("bp_held_data",  data_o,       at(3, 8'hA5));
    value_i = 8'h22; sel_i = 4'd2;
    #1;
    chk("bp_other_ready", 64'(ready_o), 64'(1));
    tick();
    chk("bp_other_valid", 64'(valid_o), 64'(8'h0C));
    chk("bp_other_data",  data_o,       at(3, 8'hA5) | at(2, 8'h22));
    ready_i = 8'hFF;
    value_i = 8'h5A; sel_i = 4'd3;
    #1;
    chk("bp_release_ready", 64'(ready_o), 64'(1));
    tick();
    chk("bp_second_valid", 64'(valid_o), 64'(8'h08));
    chk("bp_second_data",  data_o,       at(3, 8'h5A));
    valid_i = 1'b0;
    tick();
    chk("bp_end_valid", 64'(valid_o), 64'(0));
    chk("bp_end_data",  data_o,       64'(0));

    // Drain and reload channel 0 every cycle.
    sel_i = 4'd0; valid_i = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      value_i = 8'(v);
      #1;
      chk("dr_ready", 64'(ready_o), 64'(1));
      tick();
      chk("dr_valid", 64'(valid_o), 64'(8'h01));
      chk("dr_data",  data_o,       at(0, 8'(v)));
    end
    valid_i = 1'b0;
    tick();
    chk("dr_end_valid", 64'(valid_o), 64'(0));

    // Out-of-range selects are accepted, dropped and counted.
    value_i = 8'h77; sel_i = 4'd8; valid_i = 1'b1;
    #1;
    chk("oor8_ready", 64'(ready_o), 64'(1));
    tick();
    chk("oor8_valid",   64'(valid_o),   64'(0));
    chk("oor8_err",     64'(err_o),     64'(1));
    chk("oor8_err_cnt", 64'(err_cnt_o), 64'(1));
    valid_i = 1'b0;
    tick();
    chk("oor_gap_err", 64'(err_o), 64'(0));
    sel_i = 4'd15; valid_i = 1'b1;
    #1;
    chk("oor15_ready", 64'(ready_o), 64'(1));
    tick();
    chk("oor15_valid",   64'(valid_o),   64'(0));
    chk("oor15_err",     64'(err_o),     64'(1));
    chk("oor15_err_cnt", 64'(err_cnt_o), 64'(2));
    valid_i = 1'b0;
    tick();
    chk("oor_end_err",     64'(err_o),     64'(0));
    chk("oor_end_err_cnt", 64'(err_cnt_o), 64'(2));

    // 300 more dropped beats: 2 + 252 = 254, then saturation at 255.
    valid_i = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (n == 252) chk("sat_254", 64'(err_cnt_o), 64'(254));
      if (n == 253) chk("sat_255", 64'(err_cnt_o), 64'(255));
    end
    chk("sat_err_cnt", 64'(err_cnt_o), 64'(255));
    chk("sat_err",     64'(err_o),     64'(1));
    chk("sat_valid",   64'(valid_o),   64'(0));
    valid_i = 1'b0;
    tick();
    chk("sat_hold_err_cnt", 64'(err_cnt_o), 64'(255));

    // IDLE_ZERO comparison on channel 5.
    ready_i = 8'h00;
    value_i = 8'h3C; sel_i = 4'd5; valid_i = 1'b1;
    tick();
    chk("iz_load_valid_h", 64'(valid_o_h),        64'(8'h20));
    chk("iz_load_data_h",  64'(data_o_h[47:40]),  64'(8'h3C));
    valid_i = 1'b0;
    ready_i = 8'hFF;
    tick();
    chk("iz_drain_valid_h", 64'(valid_o_h),       64'(0));
    chk("iz_drain_data_h",  64'(data_o_h[47:40]), 64'(8'h3C));
    chk("iz_drain_valid",   64'(valid_o),         64'(0));
    chk("iz_drain_data",    data_o,               64'(0));

    // Async reset with channels 1 and 6 full and stalled.
    ready_i = 8'h00;
    value_i = 8'h11; sel_i = 4'd1; valid_i = 1'b1;
    tick();
    value_i = 8'h66; sel_i = 4'd6;
    tick();
    valid_i = 1'b0;
    chk("ar_pre_valid", 64'(valid_o), 64'(8'h42));
    chk("ar_pre_data",  data_o,       at(1, 8'h11) | at(6, 8'h66));
    #2;
    rst_i = 1'b0;
    #1;
    chk("ar_valid",   64'(valid_o),   64'(0));
    chk("ar_data",    data_o,         64'(0));
    chk("ar_data_h",  data_o_h,       64'(0));
    chk("ar_err_cnt", 64'(err_cnt_o), 64'(0));
    chk("ar_ready",   64'(ready_o),   64'(0));
    tick();
    rst_i = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
# demux_stream

Parametrised, registered 1-to-CHANNELS stream demultiplexer with a valid/ready handshake on the input and on every output channel. Each output channel owns a one-entry holding register, so a stalled channel back-pressures only beats addressed to it. Out-of-range selects are dropped and counted. The block is the successor to the fixed 8-port combinational demux and sits between a single producer and up to CHANNELS independent consumers.

## Interface
- WIDTH, 8, data width per beat and per channel
- CHANNELS, 8, number of output channels (>= 2)
- SEL_W, 4, select width; must satisfy 2**SEL_W >= CHANNELS; codes >= CHANNELS are out of range
- IDLE_ZERO, 1, 1: a channel's data slice returns to 0 when drained; 0: the slice holds its last value
- clk_i  input  1  single clock, rising edge
- rst_i  input  1  reset; asynchronous assert, active-low, synchronous deassert expected from the system
- value_i  input  WIDTH  input beat data
- sel_i  input  SEL_W  destination channel, sampled with value_i
- valid_i  input  1  input beat valid
- ready_o  output  1  block accepts the beat this cycle
- data_o  output  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- valid_o  output  CHANNELS  channel k holds a beat
- ready_i  input  CHANNELS  consumer k accepts a beat
- err_o  output  1  one-cycle pulse: an out-of-range beat was dropped
- err_cnt_o  output  8  saturating count of dropped beats

## Operation
- An input transfer occurs on a rising edge where valid_i && ready_o. An output transfer on channel k occurs where valid_o[k] && ready_i[k].
- ready_o is combinational:
  - in range (sel_i < CHANNELS): ready_o = !valid_o[sel_i] || ready_i[sel_i];
  - out of range: ready_o = 1;
  - ready_o = 0 while rst_i is low.
- On an in-range input transfer: data_o slice[sel_i] <= value_i and valid_o[sel_i] <= 1.
- On an output transfer of channel k with no load into k in the same cycle: valid_o[k] <= 0; slice k <= 0 when IDLE_ZERO=1, otherwise unchanged.
- Simultaneous drain and load of the same channel: the new beat replaces the old one, valid_o[k] stays 1, and no bubble is inserted.
- Channels are independent. A load into channel j never disturbs channel k != j. Several channels may drain in the same cycle.
- Out-of-range input transfer: the beat is dropped, err_o = 1 next cycle for one cycle, and err_cnt_o increments, saturating at 255.
- No state machine beyond the per-channel full flag, which takes two states per channel:
  - EMPTY -> FULL on load;
  - FULL -> EMPTY on drain without reload;
  - FULL -> FULL on drain+reload or on stall.
- valid_i dropping without a transfer is allowed; no stability rule is imposed on the producer beyond standard valid/ready.

## Timing
- Reset (rst_i low, asynchronous): data_o = 0, valid_o = 0, err_o = 0, err_cnt_o = 0, ready_o = 0. First acceptance is possible on the first edge after rst_i rises.
- Latency: input transfer at edge n gives valid_o[sel] = 1 and data after edge n, visible for sampling at edge n+1.
- Throughput: one beat per cycle to any mix of channels while the addressed ready_i is high.
- Combinational paths: ready_i and sel_i to ready_o. There is no path from value_i to data_o.
- Reset mid-operation: all held beats are discarded and counters cleared immediately, without waiting for a clock.
- err_o is registered, one cycle after the dropping edge; err_cnt_o updates on the same edge as err_o.

## Test plan
- Reset then sweep: hold ready_i = all ones, send value_i = 0..31 with sel_i = i%8.
  - Each beat appears on channel i%8 one cycle later.
  - valid_o is a single one-hot pulse per beat.
  - Drained slices return to 0 (IDLE_ZERO=1).
- Back-pressure: ready_i[3] = 0, send 0xA5 then 0x5A to sel 3.
  - 0xA5 is held and ready_o = 0 for the second beat.
  - Meanwhile beats to sel 2 pass.
  - Raising ready_i[3] delivers 0xA5, then 0x5A on the following cycle with no lost beat.
- Drain+reload: ready_i[0] = 1, sel 0 every cycle with values 1,2,3.
  - valid_o[0] stays high three consecutive cycles with data 1,2,3.
- Out-of-range: sel_i = 8 and 15 with valid_i = 1.
  - ready_o = 1, no valid_o asserted, err_o pulses twice, err_cnt_o = 2.
  - 300 such beats saturate err_cnt_o at 255.
- IDLE_ZERO=0 build: send 0x3C to channel 5, then drain it.
  - valid_o[5] falls and slice 5 keeps 0x3C.
- Async reset while channels 1 and 6 are FULL and ready_i = 0:
  - valid_o = 0, data_o = 0 and err_cnt_o = 0 immediately, without a clock edge.
